// File: rtl/busid_arb_pkg.sv
// busid_arb_pkg: shared types, sizes and bus-ID slice helper for the bus-ID arbiter
package busid_arb_pkg;
  localparam int N_REQ = 4;
  localparam int ID_W = 5;
  localparam int TIMEOUT_CYC_DEF = 1024;
  typedef enum logic [1:0] {IDLE, GRANT, HOLD, RELEASE} state_t;
  function automatic logic [ID_W-1:0] id_of(input logic [N_REQ*ID_W-1:0] ids, input int i);
    return ids[i*ID_W +: ID_W];
  endfunction
endpackage

// File: rtl/busid_rr_arbiter_if.sv
// busid_rr_arbiter_if: requester-side and buffer-side signals of the bus-ID arbiter
interface busid_rr_arbiter_if;
  import busid_arb_pkg::*;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ*ID_W-1:0] bus_id_in;
  logic [N_REQ-1:0] buffer_en;
  logic [ID_W-1:0] bus_id_out;
  logic grant_valid;
  logic [1:0] grant_idx;
  logic timeout_err;
  modport master (output req, done, bus_id_in, input buffer_en, bus_id_out, grant_valid, grant_idx, timeout_err);
  modport slave (input req, done, bus_id_in, output buffer_en, bus_id_out, grant_valid, grant_idx, timeout_err);
endinterface

// File: rtl/busid_rr_pick.sv
// busid_rr_pick: first set request at or after ptr, searching upward modulo 4
module busid_rr_pick
  import busid_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic             any_req,
  output logic [1:0]       win
);
  // scan farthest offset first so the nearest set request overwrites it
  always_comb begin
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[2'(int'(ptr) + k)]) win = 2'(int'(ptr) + k);
    any_req = |req;
  end
endmodule

// File: rtl/busid_rr_arbiter.sv
// busid_rr_arbiter: round-robin owner of the shared bus-ID buffer; watchdog under BUSID_ARB_TIMEOUT_EN
module busid_rr_arbiter
  import busid_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic clk,
  input logic rst,
  busid_rr_arbiter_if.slave bus
);
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d, ptr_q, ptr_d, win;
  logic [ID_W-1:0] id_q, id_d;
  logic any_req, rel, expire;
  busid_rr_pick u_pick (.req(bus.req), .ptr(ptr_q), .any_req(any_req), .win(win));
  assign rel = bus.done[idx_q] | ~bus.req[idx_q];
`ifdef BUSID_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic to_q, to_d;
  assign expire = cnt_q == 16'(TIMEOUT_CYC - 1);
  // watchdog counts HOLD cycles; the error flag is set only when expiry alone ends HOLD
  always_comb begin
    cnt_d = state_q == HOLD ? cnt_q + 16'd1 : '0;
    to_d = state_q == HOLD && expire && !rel;
  end
  // watchdog registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q <= to_d;
    end
  assign bus.timeout_err = to_q;
`else
  assign expire = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif
  // next state; owner index and ID are latched on the IDLE->GRANT edge and then held
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    id_d = id_q;
    ptr_d = ptr_q;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = GRANT;
        idx_d = win;
        id_d = id_of(bus.bus_id_in, int'(win));
      end
      GRANT: state_d = HOLD;
      HOLD: if (rel || expire) state_d = RELEASE;
      RELEASE: begin
        state_d = IDLE;
        ptr_d = idx_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      id_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
    end
  assign bus.grant_valid = state_q == GRANT || state_q == HOLD;
  assign bus.buffer_en = state_q == GRANT ? 4'b0001 << idx_q : 4'b0000;
  assign bus.bus_id_out = id_q;
  assign bus.grant_idx = idx_q;
endmodule

// File: tb/tb_busid_rr_arbiter.sv
// tb_busid_rr_arbiter: directed stimulus, cycle model compare, literal spot checks
module tb_busid_rr_arbiter;
  localparam int TO = 8;
`ifdef BUSID_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  busid_rr_arbiter_if bus ();
  busid_rr_arbiter #(.TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  // model: phase 0 idle, 1 grant, 2 hold, 3 release; cnt = hold cycles elapsed
  int ph, cnt, m_ptr, m_idx, m_id;
  bit m_to;
  always @(posedge clk or posedge rst)
    if (rst) begin
      ph = 0; cnt = 0; m_ptr = 0; m_idx = 0; m_id = 0; m_to = 0;
    end else if (ph == 0) begin
      for (int k = 3; k >= 0; k--)
        if (bus.req[(m_ptr + k) % 4]) begin
          m_idx = (m_ptr + k) % 4;
          ph = 1;
        end
      if (ph == 1) m_id = int'(bus.bus_id_in[5*m_idx +: 5]);
    end else if (ph == 1) begin
      ph = 2; cnt = 0;
    end else if (ph == 2) begin
      if (bus.done[m_idx] || !bus.req[m_idx] || (TO_EN && cnt == TO - 1)) begin
        m_to = !(bus.done[m_idx] || !bus.req[m_idx]);
        ph = 3;
      end else cnt++;
    end else begin
      m_ptr = (m_idx + 1) % 4; ph = 0; m_to = 0;
    end
  always @(negedge clk) begin
    chk("m_valid", 32'(bus.grant_valid), 32'(ph == 1 || ph == 2));
    chk("m_buffer_en", 32'(bus.buffer_en), ph == 1 ? 32'(1) << m_idx : 0);
    chk("m_idx", 32'(bus.grant_idx), 32'(m_idx));
    chk("m_id", 32'(bus.bus_id_out), 32'(m_id));
    chk("m_timeout", 32'(bus.timeout_err), 32'(ph == 3 && m_to));
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
  endtask
  task automatic wait_grant;
    int n = 0;
    while (bus.buffer_en == 0 && n < 20) begin
      tick;
      n++;
    end
    chk("grant_wait", 32'(n < 20), 1);
  endtask
  initial begin
    bus.req = '0;
    bus.done = '0;
    bus.bus_id_in = {5'h1c, 5'h12, 5'h11, 5'h10};
    repeat (2) tick;
    rst = 1'b0;
    chk("rst_valid", 32'(bus.grant_valid), 0);
    chk("rst_id", 32'(bus.bus_id_out), 0);
    tick;
    // single request on channel 2
    bus.req = 4'b0100;
    tick;
    chk("g2_en", 32'(bus.buffer_en), 4);
    chk("g2_idx", 32'(bus.grant_idx), 2);
    chk("g2_id", 32'(bus.bus_id_out), 32'h12);
    chk("g2_valid", 32'(bus.grant_valid), 1);
    bus.bus_id_in[14:10] = 5'h07;
    tick;
    chk("g2_en_off", 32'(bus.buffer_en), 0);
    chk("g2_id_held", 32'(bus.bus_id_out), 32'h12);
    bus.done = 4'b0100;
    bus.req = 4'b0000;
    tick;
    chk("g2_rel", 32'(bus.grant_valid), 0);
    bus.done = '0;
    bus.bus_id_in[14:10] = 5'h12;
    tick;
    // full round robin
    do_reset;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant;
      chk("rr_idx", 32'(bus.grant_idx), 32'(k % 4));
      tick;
      tick;
      bus.done = 4'b0001 << (k % 4);
      tick;
      chk("rr_rel", 32'(bus.grant_valid), 0);
      bus.done = '0;
      tick;
      chk("rr_idle", 32'(bus.buffer_en), 0);
    end
    bus.req = '0;
    repeat (4) tick;
    // watchdog with channel 1 silent
    do_reset;
    bus.req = 4'b0110;
    tick;
    chk("to_g1", 32'(bus.grant_idx), 1);
    if (TO_EN) begin
      for (int i = 0; i < TO; i++) begin
        tick;
        chk("to_hold", 32'(bus.grant_valid), 1);
      end
      tick;
      chk("to_err", 32'(bus.timeout_err), 1);
      tick;
      chk("to_err_off", 32'(bus.timeout_err), 0);
      tick;
      chk("to_next", 32'(bus.grant_idx), 2);
    end else begin
      repeat (30) tick;
      chk("nt_hold", 32'(bus.grant_valid), 1);
      chk("nt_idx", 32'(bus.grant_idx), 1);
    end
    bus.req = '0;
    repeat (4) tick;
    // done on final hold cycle; foreign done ignored
    do_reset;
    bus.req = 4'b0010;
    tick;
    tick;
    bus.done = 4'b1000;
    repeat (TO - 1) tick;
    chk("fd_hold", 32'(bus.grant_valid), 1);
    bus.done = 4'b1010;
    tick;
    chk("fd_rel", 32'(bus.grant_valid), 0);
    chk("fd_noerr", 32'(bus.timeout_err), 0);
    bus.done = '0;
    bus.req = '0;
    repeat (2) tick;
    // async reset in the middle of HOLD
    do_reset;
    bus.req = 4'b0001;
    tick;
    tick;
    chk("ar_hold", 32'(bus.grant_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(bus.grant_valid), 0);
    chk("ar_en", 32'(bus.buffer_en), 0);
    tick;
    rst = 1'b0;
    bus.req = 4'b0011;
    tick;
    chk("ar_g0", 32'(bus.grant_idx), 0);
    chk("ar_g0_en", 32'(bus.buffer_en), 1);
    tick;
    bus.done = 4'b0001;
    tick;
    bus.done = '0;
    tick;
    tick;
    chk("ar_g1", 32'(bus.grant_idx), 1);
    chk("ar_g1_id", 32'(bus.bus_id_out), 32'h11);
    bus.req = '0;
    repeat (3) tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
